// File: rtl/uart_tx_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and serialiser state encoding.
package uart_tx_io_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h04;
  localparam logic [4:0] ADDR_BAUD   = 5'h08;

  // Offsets are word aligned, so decode compares the word index only
  localparam logic [2:0] WORD_TXDATA = ADDR_TXDATA[4:2];
  localparam logic [2:0] WORD_STATUS = ADDR_STATUS[4:2];
  localparam logic [2:0] WORD_BAUD   = ADDR_BAUD[4:2];

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_io_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees a
// slot on the same edge. Storage is not reset, only pointers and count.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push & (~full | pop);
  assign pop_ok    = pop & ~empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, push_ok} - {{(CNT_W-1){1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: register decode, byte FIFO and an
// LSB-first serialiser with registered tx and irq outputs.
module uart_tx_io
  import uart_tx_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [4:0]  IOAdr,
  input  logic [31:0] WriteIO,
  input  logic        IOWrite,
  output logic [31:0] ReadIO,
  output logic        tx,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_q, baud_d;
  logic        ovf_q, ovf_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;

  logic             push_req, stat_wr, baud_wr, fifo_pop, baud_end;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count, fifo_count_nxt;
  logic             unused_ok;

  assign push_req  = sel & IOWrite & (IOAdr[4:2] == WORD_TXDATA);
  assign stat_wr   = sel & IOWrite & (IOAdr[4:2] == WORD_STATUS);
  assign baud_wr   = sel & IOWrite & (IOAdr[4:2] == WORD_BAUD);
  assign unused_ok = ^{WriteIO[31:16], IOAdr[1:0]};

  sync_fifo #(
    .DATA_W(8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .pop      (fifo_pop),
    .wdata    (WriteIO[7:0]),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .count_nxt(fifo_count_nxt)
  );

  assign baud_end = (baud_cnt_q == div_q - 16'd1);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q + 16'd1;
    div_d      = div_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = baud_cnt_q;
        fifo_pop   = ~fifo_empty;
      end
      ST_START: begin
        if (baud_end) begin
          state_d    = ST_DATA;
          baud_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          fifo_pop   = ~fifo_empty;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Divisor is captured here so BAUDDIV writes only affect later frames
    if (fifo_pop) begin
      state_d    = ST_START;
      shift_d    = fifo_rdata;
      bit_cnt_d  = '0;
      baud_cnt_d = '0;
      div_d      = baud_q;
    end
    tx_d  = (state_d == ST_START) ? 1'b0 :
            (state_d == ST_DATA)  ? shift_d[0] : 1'b1;
    irq_d = (fifo_count_nxt == '0) && (state_d == ST_IDLE);
  end

  always_comb begin
    baud_d = baud_q;
    if (baud_wr) baud_d = (WriteIO[15:0] == 16'd0) ? 16'd1 : WriteIO[15:0];
    ovf_d = ovf_q;
    if (stat_wr && WriteIO[STAT_OVF]) ovf_d = 1'b0;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_comb begin
    ReadIO = '0;
    case (IOAdr[4:2])
      WORD_STATUS: begin
        ReadIO[STAT_BUSY]                 = (state_q != ST_IDLE);
        ReadIO[STAT_FULL]                 = fifo_full;
        ReadIO[STAT_EMPTY]                = fifo_empty;
        ReadIO[STAT_OVF]                  = ovf_q;
        ReadIO[STAT_CNT_MSB:STAT_CNT_LSB] = 5'(fifo_count);
      end
      WORD_BAUD: ReadIO[15:0] = baud_q;
      default:   ReadIO = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      div_q      <= 16'(DIV_RESET);
      baud_q     <= 16'(DIV_RESET);
      ovf_q      <= 1'b0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      baud_q     <= baud_d;
      ovf_q      <= ovf_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// Scoreboard bench for uart_tx_io: stimulus queues expected register reads
// and serial frames; independent monitors pop and compare them.
module tb_uart_tx_io;

  localparam logic [4:0] A_TX   = 5'h00;
  localparam logic [4:0] A_STAT = 5'h04;
  localparam logic [4:0] A_BAUD = 5'h08;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        IOWrite = 1'b0;
  logic [4:0]  IOAdr = '0;
  logic [31:0] WriteIO = '0;
  logic [31:0] ReadIO;
  logic        tx, irq;

  always #5 clk = ~clk;

  uart_tx_io #(.FIFO_DEPTH(8), .DIV_RESET(868)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .IOAdr  (IOAdr),
    .WriteIO(WriteIO),
    .IOWrite(IOWrite),
    .ReadIO (ReadIO),
    .tx     (tx),
    .irq    (irq)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
    longint     start;     // -1: must follow the previous frame with no gap
    bit         abort_ok;  // frame is expected to be cut short by reset
  } frame_t;

  typedef struct {
    logic [31:0] rdata;
    logic        etx;
    logic        eirq;
    bit          pins;
    string       name;
  } rd_t;

  frame_t fq[$];
  rd_t    rq[$];
  logic   chk = 1'b0;
  bit     mon_busy = 1'b0;
  longint last_end = -10;

  // Register/pin monitor
  initial begin
    rd_t e;
    forever begin
      @(negedge clk);
      if (chk) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rd_queue: read strobe with no expected entry, ReadIO=%h", ReadIO);
        end else begin
          e = rq.pop_front();
          if (ReadIO !== e.rdata || (e.pins && (tx !== e.etx || irq !== e.eirq))) begin
            errors++;
            $display("FAIL %s: got ReadIO=%h tx=%b irq=%b, required ReadIO=%h tx=%b irq=%b",
                     e.name, ReadIO, tx, irq, e.rdata, e.etx, e.eirq);
          end
        end
      end
    end
  end

  // Serial line monitor
  initial begin
    frame_t     f;
    int         nerr, b;
    bit         aborted, start_ok;
    logic       ebit;
    logic [7:0] obs;
    longint     st;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: tx low at cyc %0d, required idle high", cyc);
          while (tx === 1'b0) @(negedge clk);
        end else begin
          mon_busy = 1'b1;
          f = fq.pop_front();
          st = cyc;
          start_ok = (f.start < 0) ? (cyc == last_end + 1) : (cyc == f.start);
          nerr = 0;
          aborted = 1'b0;
          obs = '0;
          for (int i = 0; i < 10 * f.div; i++) begin
            if (i > 0) @(negedge clk);
            b = i / f.div;
            ebit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : f.data[b-1];
            if (tx !== ebit) nerr++;
            if (b >= 1 && b <= 8 && (i % f.div) == f.div / 2) obs[b-1] = tx;
            if (reset) begin
              aborted = 1'b1;
              break;
            end
          end
          last_end = cyc;
          if (nerr != 0 || !start_ok || aborted != f.abort_ok) begin
            errors++;
            $display("FAIL frame_%02h: start_cyc=%0d bit_errs=%0d obs=%02h aborted=%0d, required start=%0d bit_errs=0 data=%02h aborted=%0d",
                     f.data, st, nerr, obs, aborted, f.start, f.data, f.abort_ok);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    sel     = 1'b0;
    IOWrite = 1'b0;
    chk     = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc_start();
    sel     = 1'b1;
    IOWrite = 1'b1;
    IOAdr   = a;
    WriteIO = d;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input bit pins,
                    input logic etx, input logic eirq, input string name);
    rd_t e;
    cyc_start();
    IOAdr   = a;
    chk     = 1'b1;
    e.rdata = exp;
    e.etx   = etx;
    e.eirq  = eirq;
    e.pins  = pins;
    e.name  = name;
    rq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_start();
  endtask

  task automatic wait_until(input longint t);
    cyc_start();
    while (cyc < t) cyc_start();
  endtask

  task automatic exp_frame(input logic [7:0] d, input int div, input longint start, input bit ab);
    frame_t f;
    f.data = d;
    f.div = div;
    f.start = start;
    f.abort_ok = ab;
    fq.push_back(f);
  endtask

  initial begin
    longint c, c0;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state and decode
    rd(A_STAT, 32'h4, 1, 1'b1, 1'b1, "rst_status");
    rd(A_BAUD, 32'd868, 1, 1'b1, 1'b1, "rst_baud");
    rd(A_TX, 32'h0, 0, 1'b1, 1'b1, "txdata_reads0");
    rd(5'h14, 32'h0, 0, 1'b1, 1'b1, "unmapped_reads0");
    rd(5'h06, 32'h4, 0, 1'b1, 1'b1, "status_low_bits_ignored");
    wr(5'h0C, 32'h1234);
    rd(A_BAUD, 32'd868, 0, 1'b1, 1'b1, "unmapped_write_ignored");

    // Single frame, div 4
    wr(A_BAUD, 32'd4);
    wr(A_TX, 32'h55);
    c = cyc;
    exp_frame(8'h55, 4, c + 2, 1'b0);
    rd(A_STAT, 32'h10, 1, 1'b1, 1'b0, "t2_queued");
    rd(A_STAT, 32'h5, 1, 1'b0, 1'b0, "t2_start");
    idle(30);
    rd(A_STAT, 32'h5, 1, 1'b1, 1'b0, "t2_mid_frame");
    idle(7);
    rd(A_STAT, 32'h5, 1, 1'b1, 1'b0, "t2_last_stop_cycle");
    rd(A_STAT, 32'h4, 1, 1'b1, 1'b1, "t2_done");

    // Back-to-back frames, div 2
    wr(A_BAUD, 32'd2);
    wr(A_TX, 32'hA5);
    c = cyc;
    exp_frame(8'hA5, 2, c + 2, 1'b0);
    wr(A_TX, 32'h3C);
    exp_frame(8'h3C, 2, -1, 1'b0);
    rd(A_STAT, 32'h11, 1, 1'b0, 1'b0, "t3_second_queued");
    idle(41);
    rd(A_STAT, 32'h4, 1, 1'b1, 1'b1, "t3_done");

    // Overflow, div 1000
    wr(A_BAUD, 32'd1000);
    wr(A_TX, 32'h11);
    c0 = cyc;
    exp_frame(8'h11, 1000, c0 + 2, 1'b0);
    exp_frame(8'h22, 1000, -1, 1'b1);
    for (int j = 2; j <= 8; j++) wr(A_TX, 32'(j * 8'h11));
    rd(A_STAT, 32'h71, 1, 1'b0, 1'b0, "t4_count7");
    wr(A_TX, 32'h99);
    rd(A_STAT, 32'h83, 1, 1'b0, 1'b0, "t4_full");
    wr(A_TX, 32'hAA);
    rd(A_STAT, 32'h8B, 1, 1'b0, 1'b0, "t4_overflow");
    wr(A_STAT, 32'h8);
    rd(A_STAT, 32'h83, 1, 1'b0, 1'b0, "t4_ovf_cleared");

    // Push on the edge where STOP pops while full
    wait_until(c0 + 10000);
    wr(A_TX, 32'hBB);
    rd(A_STAT, 32'h83, 1, 1'b0, 1'b0, "t5_simul_push_pop");

    // Reset during DATA bit 3 of the second frame
    wait_until(c0 + 14500);
    cyc_start();
    reset = 1'b1;
    rd(A_STAT, 32'h4, 1, 1'b1, 1'b1, "t6_reset_status");
    rd(A_BAUD, 32'd868, 0, 1'b1, 1'b1, "t6_reset_baud");

    // Divisor of zero stores one
    wr(A_BAUD, 32'd0);
    rd(A_BAUD, 32'd1, 0, 1'b1, 1'b1, "t6_baud0_reads1");
    wr(A_TX, 32'hFF);
    c = cyc;
    exp_frame(8'hFF, 1, c + 2, 1'b0);
    idle(10);
    rd(A_STAT, 32'h5, 1, 1'b1, 1'b0, "t6_div1_last_cycle");
    rd(A_STAT, 32'h4, 1, 1'b1, 1'b1, "t6_div1_done");

    for (int i = 0; i < 100 && (fq.size() != 0 || mon_busy); i++) cyc_start();
    idle(2);
    checks++;
    if (fq.size() != 0 || mon_busy) begin
      errors++;
      $display("FAIL frames_pending: %0d expected frames never seen, required 0", fq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
